// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler
//   Waits INIT_DELAY cycles after reset, then produces one refresh tick every
//   REF_INTERVAL cycles while running. Ticks accumulate in a pending count
//   (up to MAX_POSTPONE) that the command stage drains with ref_ack pulses.
//   The request level is decoded from the registered pending count.
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST_N      : synchronous active-low reset
//   enable     : 1 lets the interval counter run, 0 parks the scheduler in HOLD
//   ref_ack    : one-cycle pulse, one refresh has been issued
//   do_refresh : 0 none, 1 normal request, 2 urgent request (backlog full)
//   pending    : number of owed refreshes
//   init_done  : high once the power-up wait has completed
//   err        : sticky flag for backlog overflow or ack with nothing owed
module sdram_refresh_scheduler #(
  parameter int unsigned INIT_DELAY   = 20000,
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       enable,
  input  logic       ref_ack,
  output logic [1:0] do_refresh,
  output logic [3:0] pending,
  output logic       init_done,
  output logic       err
);

  localparam int unsigned IW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam int unsigned CW = $clog2(REF_INTERVAL);

  localparam logic [IW-1:0] INIT_LAST = IW'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RELOAD    = CW'(REF_INTERVAL - 1);
  localparam logic [3:0]    PEND_MAX  = 4'(MAX_POSTPONE);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HOLD
  } state_e;

  state_e          state_q,      state_d;
  logic [IW-1:0]   init_cnt_q,   init_cnt_d;
  logic [CW-1:0]   intv_cnt_q,   intv_cnt_d;
  logic [3:0]      pending_q,    pending_d;
  logic [1:0]      do_refresh_q, do_refresh_d;
  logic            init_done_q,  init_done_d;
  logic            err_q,        err_d;
  logic            tick;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    intv_cnt_d   = intv_cnt_q;
    pending_d    = pending_q;
    init_done_d  = init_done_q;
    err_d        = err_q;
    tick         = 1'b0;

    // Request level follows the registered count one cycle later.
    if (pending_q == '0) begin
      do_refresh_d = 2'd0;
    end else if (pending_q >= PEND_MAX) begin
      do_refresh_d = 2'd2;
    end else begin
      do_refresh_d = 2'd1;
    end

    case (state_q)
      ST_INIT: begin
        pending_d = '0;
        if (init_cnt_q == INIT_LAST) begin
          state_d     = enable ? ST_RUN : ST_HOLD;
          init_done_d = 1'b1;
          intv_cnt_d  = RELOAD;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Counting is tied to the registered state, so the cycle on which
        // enable=0 is sampled still advances the counter before HOLD freezes it.
        if (intv_cnt_q == '0) begin
          tick       = 1'b1;
          intv_cnt_d = RELOAD;
        end else begin
          intv_cnt_d = intv_cnt_q - 1'b1;
        end
        if (!enable) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (state_q != ST_INIT) begin
      case ({tick, ref_ack})
        2'b10: begin
          if (pending_q == PEND_MAX) begin
            err_d = 1'b1;
          end else begin
            pending_d = pending_q + 1'b1;
          end
        end
        2'b01: begin
          if (pending_q == '0) begin
            err_d = 1'b1;
          end else begin
            pending_d = pending_q - 1'b1;
          end
        end
        2'b11: begin
          // Coincident tick and ack cancel, unless the ack was spurious.
          if (pending_q == '0) begin
            err_d     = 1'b1;
            pending_d = 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      intv_cnt_q   <= RELOAD;
      pending_q    <= '0;
      do_refresh_q <= '0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      intv_cnt_q   <= intv_cnt_d;
      pending_q    <= pending_d;
      do_refresh_q <= do_refresh_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
    end
  end

  assign do_refresh = do_refresh_q;
  assign pending    = pending_q;
  assign init_done  = init_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Testbench for sdram_refresh_scheduler: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model that
// counts running cycles and applies the refresh bookkeeping rules directly.
module tb_sdram_refresh_scheduler;

  localparam int unsigned P_INIT = 5;
  localparam int unsigned P_INT  = 10;
  localparam int unsigned P_MAX  = 4;

  logic       CLK     = 1'b0;
  logic       RST_N   = 1'b0;
  logic       enable  = 1'b0;
  logic       ref_ack = 1'b0;
  logic [1:0] do_refresh;
  logic [3:0] pending;
  logic       init_done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_init_edges;
  bit m_inited;
  bit m_running;
  int m_run_edges;
  int m_pend;
  bit m_err;
  int m_dr;

  sdram_refresh_scheduler #(
    .INIT_DELAY  (P_INIT),
    .REF_INTERVAL(P_INT),
    .MAX_POSTPONE(P_MAX)
  ) u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .enable    (enable),
    .ref_ack   (ref_ack),
    .do_refresh(do_refresh),
    .pending   (pending),
    .init_done (init_done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic int decode(input int p);
    if (p == 0) return 0;
    if (p >= int'(P_MAX)) return 2;
    return 1;
  endfunction

  function automatic bit model_next_tick();
    return m_inited && m_running && (((m_run_edges + 1) % int'(P_INT)) == 0);
  endfunction

  task automatic model_edge(input bit rst_n, input bit en, input bit ack);
    int old_pend;
    bit tick;
    old_pend = m_pend;
    tick     = 1'b0;
    if (!rst_n) begin
      m_init_edges = 0;
      m_inited     = 1'b0;
      m_running    = 1'b0;
      m_run_edges  = 0;
      m_pend       = 0;
      m_err        = 1'b0;
      m_dr         = 0;
      return;
    end
    if (!m_inited) begin
      m_init_edges++;
      if (m_init_edges == int'(P_INIT)) begin
        m_inited    = 1'b1;
        m_running   = en;
        m_run_edges = 0;
      end
    end else begin
      if (m_running) begin
        m_run_edges++;
        tick = ((m_run_edges % int'(P_INT)) == 0);
      end
      m_running = en;
      if (ack && m_pend == 0) begin
        m_err  = 1'b1;
        m_pend = tick ? 1 : 0;
      end else if (tick && !ack && m_pend == int'(P_MAX)) begin
        m_err = 1'b1;
      end else begin
        m_pend = m_pend + int'(tick) - int'(ack);
      end
    end
    m_dr = decode(old_pend);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pending",    16'(pending),    16'(m_pend));
    chk("do_refresh", 16'(do_refresh), 16'(m_dr));
    chk("init_done",  16'(init_done),  16'(m_inited));
    chk("err",        16'(err),        16'(m_err));
  endtask

  task automatic step(input bit en, input bit ack);
    enable  = en;
    ref_ack = ack;
    @(posedge CLK);
    model_edge(RST_N, en, ack);
    #1;
    check_all();
  endtask

  initial begin
    int lat;
    int g;
    int p0;

    // Reset state
    RST_N = 1'b0;
    step(0, 0);
    step(0, 0);
    chk("rst_pending",    16'(pending),    16'd0);
    chk("rst_do_refresh", 16'(do_refresh), 16'd0);
    chk("rst_init_done",  16'(init_done),  16'd0);
    chk("rst_err",        16'(err),        16'd0);

    // Init wait: init_done rises on the 5th edge after release
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      chk("init_still_low", 16'(init_done), 16'd0);
    end
    step(1, 0);
    chk("init_rise", 16'(init_done), 16'd1);

    // First request 11 cycles after init_done
    lat = 0;
    while (do_refresh !== 2'd1 && lat < 30) begin
      step(1, 0);
      lat++;
    end
    chk("first_req_latency", 16'(lat), 16'd11);

    // Backlog grows at 10-cycle spacing, saturates, flags overflow
    repeat (9) step(1, 0);
    chk("backlog_p2", 16'(pending), 16'd2);
    chk("backlog_dr1", 16'(do_refresh), 16'd1);
    repeat (10) step(1, 0);
    chk("backlog_p3", 16'(pending), 16'd3);
    repeat (10) step(1, 0);
    chk("backlog_p4", 16'(pending), 16'd4);
    chk("backlog_err_clear", 16'(err), 16'd0);
    step(1, 0);
    chk("urgent_dr", 16'(do_refresh), 16'd2);
    repeat (8) step(1, 0);
    chk("pre_overflow_err", 16'(err), 16'd0);
    step(1, 0);
    chk("overflow_err", 16'(err), 16'd1);
    chk("overflow_sat", 16'(pending), 16'd4);

    // Mid-run reset discards backlog and error, restarts the init wait
    step(1, 1);
    chk("drain_p3", 16'(pending), 16'd3);
    RST_N = 1'b0;
    step(1, 0);
    RST_N = 1'b1;
    chk("midrst_pending",    16'(pending),    16'd0);
    chk("midrst_do_refresh", 16'(do_refresh), 16'd0);
    chk("midrst_init_done",  16'(init_done),  16'd0);
    chk("midrst_err",        16'(err),        16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      chk("reinit_low", 16'(init_done), 16'd0);
    end
    step(1, 0);
    chk("reinit_rise", 16'(init_done), 16'd1);

    // Coincident tick and ack at pending=2
    g = 0;
    while (pending !== 4'd2 && g < 100) begin
      step(1, 0);
      g++;
    end
    chk("reach_p2", 16'(pending), 16'd2);
    g = 0;
    while (!model_next_tick() && g < 20) begin
      step(1, 0);
      g++;
    end
    step(1, 1);
    chk("coincide_pending", 16'(pending), 16'd2);
    chk("coincide_err", 16'(err), 16'd0);
    step(1, 0);
    chk("coincide_dr", 16'(do_refresh), 16'd1);

    // Spurious ack with nothing owed
    step(1, 1);
    step(1, 1);
    chk("drained", 16'(pending), 16'd0);
    chk("drained_err", 16'(err), 16'd0);
    step(1, 1);
    chk("spurious_err", 16'(err), 16'd1);
    chk("spurious_pending", 16'(pending), 16'd0);
    repeat (100) step(0, 0);
    chk("err_sticky", 16'(err), 16'd1);

    // Hold while interval counter reads 3, resume, tick after 4 cycles
    g = 0;
    while (!(m_running && (m_run_edges % int'(P_INT)) == 6) && g < 40) begin
      step(1, 0);
      g++;
    end
    p0 = m_pend;
    step(0, 0);
    repeat (50) step(0, 0);
    chk("hold_frozen", 16'(pending), 16'(p0));
    step(1, 0);
    step(1, 0);
    step(1, 0);
    chk("resume_no_tick_yet", 16'(pending), 16'(p0));
    step(1, 0);
    chk("resume_tick", 16'(pending), 16'(p0 + 1));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      RST_N = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
    end
    RST_N = 1'b1;
    step(1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
